// File: rtl/acc_burst_ctrl.sv
// acc_burst_ctrl: sequences one burst of signed samples through the shared
//   accumulator datapath, then presents the captured sum on a result port.
// Latency: start edge T0 -> CLEAR (T0+1) -> RUN from T0+2; with s_valid held
//   high the result is valid at edge T0+len+3. A zero-length burst yields 0.
// Backpressure: s_ready is high only in RUN; a low s_valid stalls the burst.
//   The result is held in OUT until m_ready; start is ignored while busy.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, len          burst request pulse and sample count (IDLE only)
//   busy                high in every state except IDLE
//   s_data/s_valid/s_ready   sample stream in (valid/ready)
//   acc_x/acc_ce/acc_clr     drive the accumulator instance
//   acc_y               registered running sum from the accumulator
//   m_data/m_valid/m_ready   captured burst sum out (valid/ready)
module acc_burst_ctrl #(
    parameter int DATA_W = 13,
    parameter int ACC_W  = 21,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] acc_x,
    output logic                     acc_ce,
    output logic                     acc_clr,
    input  logic signed [ACC_W-1:0]  acc_y,
    output logic signed [ACC_W-1:0]  m_data,
    output logic                     m_valid,
    input  logic                     m_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;

    logic run_st;
    logic fire;
    logic last_smp;

    // Sample acceptance is gated by reset so nothing reaches the accumulator
    // in a reset cycle, even if the state register still reads RUN.
    assign run_st   = (state_q == S_RUN) && !rst;
    assign fire     = run_st && s_valid;
    assign last_smp = (count_q == (len_q - LEN_W'(1)));

    assign busy    = (state_q != S_IDLE);
    assign s_ready = run_st;
    assign acc_x   = run_st ? s_data : '0;
    assign acc_ce  = fire;
    // Reset clears the accumulator on the same edge as the controller.
    assign acc_clr = rst || (state_q == S_CLEAR);
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    count_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q != '0) ? S_RUN : S_SETTLE;
            end
            S_RUN: begin
                if (fire) begin
                    count_d = count_q + LEN_W'(1);
                    if (last_smp) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // The last sample was registered by the accumulator on the
                // edge that left RUN, so acc_y is already the final sum here.
                m_data_d  = acc_y;
                m_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_acc_burst_ctrl.sv
// tb_acc_burst_ctrl: directed bench for acc_burst_ctrl with a behavioural
//   model of the signed accumulator closing the acc_* loop.
// Latency/backpressure behaviour of the DUT is checked per burst vector.
module tb_acc_burst_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               busy;
    logic signed [12:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [12:0] acc_x;
    logic               acc_ce;
    logic               acc_clr;
    logic signed [20:0] acc_y;
    logic signed [20:0] m_data;
    logic               m_valid;
    logic               m_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    acc_burst_ctrl #(.DATA_W(13), .ACC_W(21), .LEN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .acc_x   (acc_x),
        .acc_ce  (acc_ce),
        .acc_clr (acc_clr),
        .acc_y   (acc_y),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model: synchronous clear, clock enable, sign-extended add.
    always @(posedge clk) begin
        if (acc_clr) begin
            acc_y <= '0;
        end else if (acc_ce) begin
            acc_y <= acc_y + {{8{acc_x[12]}}, acc_x};
        end
    end

    typedef struct packed {
        logic [7:0]       len;
        logic [7:0][12:0] smp;
        bit               gaps;
        int               exp_sum;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int l, input int s0, input int s1,
                                input int s2, input int s3, input int s4,
                                input bit g, input int e);
        vec_t v;
        v.len    = 8'(l);
        v.smp[0] = 13'(s0);
        v.smp[1] = 13'(s1);
        v.smp[2] = 13'(s2);
        v.smp[3] = 13'(s3);
        v.smp[4] = 13'(s4);
        v.smp[5] = 13'(s4);
        v.smp[6] = 13'(s4);
        v.smp[7] = 13'(s4);
        v.gaps   = g;
        v.exp_sum = e;
        return v;
    endfunction

    // Must be called at a negedge with the DUT in IDLE. Drives start now,
    // streams the samples, and returns at the negedge where m_valid is seen
    // (or, with ack set, one cycle after the result handshake).
    task automatic run_burst(input vec_t v, input bit ack);
        int  t0, lat, idx, clr_n, bound;
        bit  tog, busy_ok, ce_ok, seen_ce, seen_rdy, got;
        idx = 0; clr_n = 0; lat = 0; tog = 1'b1;
        busy_ok = 1'b1; ce_ok = 1'b1; seen_ce = 1'b0; seen_rdy = 1'b0; got = 1'b0;
        bound = 2 * int'(v.len) + 20;
        start = 1'b1;
        len   = v.len;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        for (int k = 0; k < bound; k++) begin
            if (m_valid) begin
                got = 1'b1;
                lat = cyc - t0 + 1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            s_valid = (idx < int'(v.len)) && (!v.gaps || tog);
            s_data  = v.smp[(idx < 8) ? idx : 7];
            tog = !tog;
            #1;
            if (acc_ce !== (s_valid && s_ready)) ce_ok = 1'b0;
            if (acc_ce && !busy) ce_ok = 1'b0;
            if (s_ready) seen_rdy = 1'b1;
            if (!seen_ce && acc_clr) clr_n++;
            if (acc_ce) begin
                seen_ce = 1'b1;
                idx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("result_valid", int'(got), 1);
        chk("burst_sum", int'(m_data), v.exp_sum);
        if (!v.gaps) chk("result_latency", lat, int'(v.len) + 3);
        chk("samples_taken", idx, int'(v.len));
        chk("clr_once_before_ce", clr_n, 1);
        chk("busy_during_burst", int'(busy_ok), 1);
        chk("acc_ce_eq_fire", int'(ce_ok), 1);
        chk("s_ready_seen", int'(seen_rdy), int'(v.len != 0));
        if (ack) begin
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            chk("busy_after_ack", int'(busy), 0);
            chk("m_valid_after_ack", int'(m_valid), 0);
        end
    endtask

    vec_t vt[5];

    initial begin
        int fires;
        bit hold_ok;

        vt[0] = mk(4, 1, 2, 3, 4, 0, 1'b0, 10);
        vt[1] = mk(3, -4096, -4096, -4096, 0, 0, 1'b0, -12288);
        vt[2] = mk(5, 100, -50, 7, 0, -1, 1'b1, 56);
        vt[3] = mk(0, 0, 0, 0, 0, 0, 1'b0, 0);
        vt[4] = mk(255, 4095, 4095, 4095, 4095, 4095, 1'b0, 1044225);

        rst = 1'b1; start = 1'b0; len = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

        // Reset state, including acc_clr asserted by reset itself.
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_acc_ce", int'(acc_ce), 0);
        chk("rst_acc_x", int'(acc_x), 0);
        chk("rst_acc_clr", int'(acc_clr), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_acc_clr", int'(acc_clr), 0);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_burst(vt[i], 1'b1);
            @(negedge clk);
        end

        // Result held under backpressure; start pulses in OUT are ignored.
        run_burst(mk(2, 7, 8, 0, 0, 0, 1'b0, 15), 1'b0);
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            len   = 8'd3;
            #1;
            if (!m_valid || m_data !== 21'sd15 || !busy || s_ready || acc_ce)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("out_hold_stable", int'(hold_ok), 1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("hold_busy_fall", int'(busy), 0);
        chk("hold_m_valid_fall", int'(m_valid), 0);
        // New burst accepted on the first IDLE cycle (latency check inside).
        run_burst(mk(1, -3, 0, 0, 0, 0, 1'b0, -3), 1'b1);
        @(negedge clk);

        // Reset in the middle of a 6-sample burst.
        start = 1'b1; len = 8'd6;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 13'sd9;
        fires = 0;
        for (int k = 0; k < 20 && fires < 2; k++) begin
            #1;
            if (s_ready) fires++;
            @(negedge clk);
        end
        chk("mid_fires", fires, 2);
        chk("mid_acc_y", int'(acc_y), 18);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_acc_y", int'(acc_y), 0);
        hold_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (m_valid || busy) hold_ok = 1'b0;
            @(negedge clk);
        end
        chk("mid_rst_no_result", int'(hold_ok), 1);
        run_burst(mk(2, 5, 6, 0, 0, 0, 1'b0, 11), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
